psram_arbiter: RTL and testbench

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_psram_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_arbiter.sv
// PSRAM arbiter: round-robin ownership of a split read/write PSRAM controller
// port among NREQ requesters (0 = ADC capture, 1 = video fetch, 2 = host).
// One transaction is in flight at a time; data beats are routed combinationally
// between the owner and the controller, and a watchdog aborts stuck transfers.
module psram_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   psram_ready,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*8-1:0]      req_len,
  input  logic [NREQ*16-1:0]     req_wdata,
  input  logic [NREQ-1:0]        req_wvalid,
  output logic [NREQ-1:0]        req_wready,
  output logic [17:0]            rdata_out,
  output logic [NREQ-1:0]        rvalid_out,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [7:0]             awlen,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [15:0]            wdata,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic                   bvalid,
  output logic                   bready,
  output logic [ADDR_W-1:0]      araddr,
  output logic [7:0]             arlen,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [17:0]            rdata,
  input  logic                   rvalid
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } txn_t;

  state_t           state;
  txn_t             txn;
  logic [IDX_W-1:0] rr_ptr, own, pick, pick_nxt, cand;
  logic             pick_vld;
  logic [7:0]       pick_len, cnt;
  logic [9:0]       tcnt;
  logic             beat, last;
  int               pj;

  // Round-robin pick: scan from rr_ptr upward, lowest offset wins
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    pj       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pj   = (int'(rr_ptr) + i) % NREQ;
      cand = IDX_W'(pj);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
    pick_len = req_len[int'(pick)*8 +: 8];
    pick_nxt = (pick == IDX_W'(NREQ - 1)) ? '0 : pick + 1'b1;
  end

  // Data-phase routing between owner and controller
  always_comb begin
    beat       = 1'b0;
    wvalid     = (state == WDATA) && req_wvalid[own];
    wdata      = req_wdata[int'(own)*16 +: 16];
    req_wready = (state == WDATA) ? (gnt & {NREQ{wready}}) : '0;
    rvalid_out = (state == RDATA) ? (gnt & {NREQ{rvalid}}) : '0;
    if (state == WDATA) beat = wvalid && wready;
    if (state == RDATA) beat = rvalid;
    last       = beat && ((cnt + 8'd1) == txn.len);
  end

  assign rdata_out = rdata;
  assign awaddr    = txn.addr;
  assign awlen     = txn.len;
  assign araddr    = txn.addr;
  assign arlen     = txn.len;
  assign bready    = 1'b1;

  // Arbitration FSM with registered grant, handshake and status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      txn     <= '0;
      rr_ptr  <= '0;
      own     <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      awvalid <= 1'b0;
      arvalid <= 1'b0;
      cnt     <= '0;
      tcnt    <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (psram_ready && pick_vld) begin
            rr_ptr <= pick_nxt;
            if (pick_len == 8'd0) begin
              // Zero-length requests are bounced without touching the PSRAM
              err        <= 1'b1;
              done[pick] <= 1'b1;
            end else begin
              own      <= pick;
              gnt      <= NREQ'(1) << pick;
              txn.we   <= req_we[pick];
              txn.addr <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
              txn.len  <= pick_len;
              awvalid  <= req_we[pick];
              arvalid  <= !req_we[pick];
              cnt      <= '0;
              state    <= ADDR;
            end
          end
        end
        ADDR: begin
          if ((awvalid && awready) || (arvalid && arready)) begin
            awvalid <= 1'b0;
            arvalid <= 1'b0;
            tcnt    <= '0;
            state   <= txn.we ? WDATA : RDATA;
          end
        end
        default: begin
          // Data/response phases: completion has priority over the watchdog
          tcnt <= tcnt + 10'd1;
          if (beat) cnt <= cnt + 8'd1;
          if (state == WDATA && last) begin
            state <= RESP;
          end else if ((state == RDATA && last) || (state == RESP && bvalid)) begin
            done[own] <= 1'b1;
            gnt       <= '0;
            state     <= IDLE;
          end else if (tcnt >= TO_LAST) begin
            err   <= 1'b1;
            gnt   <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: read, write, timeout, fairness,
// zero-length rejection, psram_ready gating and reset during a write.
module tb_psram_arbiter;
  localparam int NREQ    = 3;
  localparam int ADDR_W  = 25;
  localparam int TIMEOUT = 1023;

  logic                   clk = 1'b0;
  logic                   reset_n, psram_ready;
  logic [NREQ-1:0]        req, req_we, req_wvalid, req_wready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*8-1:0]      req_len;
  logic [NREQ*16-1:0]     req_wdata;
  logic [17:0]            rdata_out, rdata;
  logic [NREQ-1:0]        rvalid_out, gnt, done;
  logic                   err;
  logic [ADDR_W-1:0]      awaddr, araddr;
  logic [7:0]             awlen, arlen;
  logic                   awvalid, awready, wvalid, wready, bvalid, bready;
  logic                   arvalid, arready, rvalid;
  logic [15:0]            wdata;

  int checks = 0;
  int errors = 0;

  psram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .psram_ready(psram_ready),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready),
    .rdata_out(rdata_out), .rvalid_out(rvalid_out), .gnt(gnt), .done(done),
    .err(err), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [7:0] len);
    req_we[p]                  = we;
    req_addr[p*ADDR_W +: ADDR_W] = a;
    req_len[p*8 +: 8]          = len;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_aw_ar_w"}, {29'd0, awvalid, arvalid, wvalid}, 0);
    chk({tag, "_wrdy_rvld"}, {26'd0, req_wready, rvalid_out}, 0);
    chk({tag, "_bready"}, 32'(bready), 1);
  endtask

  initial begin
    logic [2:0] order [6];
    int n, k, cnt;
    logic [2:0] pg;
    logic sd;

    reset_n = 1'b0; psram_ready = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_len = '0;
    req_wdata = '0; req_wvalid = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0;
    for (int i = 0; i < 6; i++) order[i] = '0;

    // Reset state
    tick(); tick();
    chk_idle_outs("rst");
    reset_n = 1'b1;
    tick();

    // Single read on port 1, arready after 2 cycles, 4 beats
    set_port(1, 1'b0, 25'h000100, 8'd4);
    req = 3'b010;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h2);
    chk("rd_arvalid", {30'd0, arvalid, awvalid}, 32'h2);
    chk("rd_araddr", 32'(araddr), 32'h100);
    chk("rd_arlen", 32'(arlen), 4);
    rvalid = 1'b1;              // stray beat during ADDR must be ignored
    #1 chk("rd_stray_rvalid", 32'(rvalid_out), 0);
    tick();
    rvalid = 1'b0;
    chk("rd_arvalid_held", 32'(arvalid), 1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rd_arvalid_drop", 32'(arvalid), 0);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1;
      rdata  = 18'h30000 + 18'(i);
      #1;
      chk("rd_rvalid_out", 32'(rvalid_out), 32'h2);
      chk("rd_rdata_out", 32'(rdata_out), 32'h30000 + i);
      chk("rd_no_early_done", 32'(done), 0);
      tick();
    end
    rvalid = 1'b0;
    chk("rd_done", 32'(done), 32'h2);
    chk("rd_gnt_drop", 32'(gnt), 0);
    req = '0;
    tick();
    chk("rd_done_pulse", 32'(done), 0);

    // Single write on port 0, len 8, wready always high
    set_port(0, 1'b1, 25'h0000A0, 8'd8);
    req_wdata[15:0] = 16'hA500;
    req_wvalid      = 3'b001;
    wready          = 1'b1;
    req             = 3'b001;
    tick();
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_awvalid", {30'd0, awvalid, arvalid}, 32'h2);
    chk("wr_awlen", 32'(awlen), 8);
    chk("wr_awaddr", 32'(awaddr), 32'hA0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("wr_wvalid", 32'(wvalid), 1);
    chk("wr_wdata", 32'(wdata), 32'hA500);
    chk("wr_nonowner_wready", 32'(req_wready[2:1]), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_wready[0]) cnt++;
      tick();
    end
    chk("wr_beats", 32'(cnt), 8);
    chk("wr_wait_resp_done", 32'(done), 0);
    chk("wr_gnt_held", 32'(gnt), 32'h1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("wr_done", 32'(done), 32'h1);
    chk("wr_gnt_drop", 32'(gnt), 0);
    chk("wr_no_err", 32'(err), 0);
    req = '0; req_wvalid = '0; wready = 1'b0;
    tick();

    // Timeout: port 2 read, len 4, only 2 beats delivered
    set_port(2, 1'b0, 25'h000200, 8'd4);
    req = 3'b100;
    tick();
    chk("to_gnt", 32'(gnt), 32'h4);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    k = 0; sd = 1'b0;
    while (!err && k < TIMEOUT + 8) begin
      rvalid = (k < 2);
      tick();
      k++;
      if (done != 0) sd = 1'b1;
    end
    rvalid = 1'b0;
    chk("to_cycles", 32'(k), TIMEOUT);
    chk("to_err", 32'(err), 1);
    chk("to_no_done", 32'(sd), 0);
    chk("to_gnt_drop", 32'(gnt), 0);
    req = '0;
    tick();
    chk("to_err_pulse", 32'(err), 0);

    // Fairness: all three held, len 1 reads; first grant also proves the
    // pointer moved past port 2 after the timeout
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 25'(p * 16), 8'd1);
    arready = 1'b1; rvalid = 1'b1;
    req = 3'b111;
    n = 0; pg = '0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (gnt != 0 && pg == 0) begin
        order[n] = gnt;
        n++;
      end
      pg = gnt;
    end
    for (int i = 0; i < 6; i++) chk("rr_order", 32'(order[i]), 32'(3'b001 << (i % 3)));
    req = '0;
    tick(); tick(); tick();
    arready = 1'b0; rvalid = 1'b0;
    chk("rr_settled", 32'(gnt), 0);

    // Zero length on port 0: err + done, no controller traffic
    set_port(0, 1'b0, 25'h000300, 8'd0);
    req = 3'b001;
    tick();
    chk("zl_err", 32'(err), 1);
    chk("zl_done", 32'(done), 32'h1);
    chk("zl_gnt", 32'(gnt), 0);
    chk("zl_no_aw_ar", {30'd0, awvalid, arvalid}, 0);
    req = '0;
    tick();
    chk("zl_pulse", {28'd0, err, done}, 0);

    // Pointer advanced past port 0: with ports 0 and 1 asking, port 1 wins
    set_port(0, 1'b0, 25'h000300, 8'd1);
    set_port(1, 1'b0, 25'h000310, 8'd1);
    arready = 1'b1; rvalid = 1'b1;
    req = 3'b011;
    tick();
    chk("zl_rr_next", 32'(gnt), 32'h2);
    req = '0;                   // dropping req mid-ownership does not abort
    tick(); tick();
    chk("zl_rr_done", 32'(done), 32'h2);
    arready = 1'b0; rvalid = 1'b0;
    tick();

    // psram_ready gating
    psram_ready = 1'b0;
    req = 3'b111;
    sd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gnt != 0) sd = 1'b1;
    end
    chk("gate_no_gnt", 32'(sd), 0);
    req = '0; psram_ready = 1'b1;
    tick();

    // Reset after 3 of 8 write beats
    set_port(0, 1'b1, 25'h000400, 8'd8);
    req_wvalid = 3'b001; wready = 1'b1;
    req = 3'b001;
    tick();
    chk("rw_gnt", 32'(gnt), 32'h1);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    tick(); tick(); tick();
    chk("rw_in_data", 32'(req_wready), 32'h1);
    reset_n = 1'b0;
    tick();
    chk_idle_outs("rw_rst");
    reset_n = 1'b1;
    tick();
    chk("rw_regnt", 32'(gnt), 32'h1);
    chk("rw_reaw", {30'd0, awvalid, arvalid}, 32'h2);
    chk("rw_relen", 32'(awlen), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
